montacarga_plant_model: RTL and testbench
=========================================

// Module: montacarga_plant_model
// PURPOSE
//  Cabin/shaft model for the 3-floor freight elevator: the far end of the motor/limit-switch interface.
//  Consumes the controller's motor drive (S0=up, S1=down) and produces limit switches FC1..FC3.
//  Cabin position is a step counter advanced by a prescaled tick; FCs are asserted within a window around each floor.
//  Used as the closed-loop plant in controller benches and as an on-board demo stand-in for the real shaft.
// PARAMETERS
//  PRESCALE     4000  clk cycles per position step while moving (4 MHz -> 1 kHz steps)
//  FLOOR_STEPS  100   steps between adjacent floors; floor1=0, floor2=FLOOR_STEPS, floor3=2*FLOOR_STEPS
//  FC_WINDOW    2     FCn active while |pos - floor_n| <= FC_WINDOW
//  POS_W        9     position width; must hold 2*FLOOR_STEPS+FC_WINDOW
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-low
//  S0         in   1      motor up command
//  S1         in   1      motor down command
//  FC1,FC2,FC3 out 1 each limit switches, registered
//  pos        out  POS_W  cabin position in steps
//  moving     out  1      high in ST_UP/ST_DN
//  floor_idx  out  2      01/10/11 = inside floor 1/2/3 window; 00 = between floors
//  fault      out  1      latched fault (constant 0 without PLANT_FAULT_EN)
// BEHAVIOUR
//  Reset (async, active-low): pos=0, prescaler=0, state=ST_STOP, FC1=1, FC2=FC3=0, floor_idx=01, moving=0, fault=0.
//  Motor code {S1,S0}: 00 stop, 01 up, 10 down, 11 illegal (treated as stop).
//  FSM: ST_STOP -01-> ST_UP; ST_STOP -10-> ST_DN; ST_UP/ST_DN -00/11-> ST_STOP; ST_UP<->ST_DN on reversal.
//  Each state change clears the prescaler; a step never carries partial time across stop or reversal.
//  In ST_UP/ST_DN the prescaler counts 0..PRESCALE-1; on wrap pos +1 (up) / -1 (down).
//  First step lands PRESCALE cycles after the motor code is sampled (state register adds 1 cycle).
//  End stops: pos saturates at 0 and at PMAX=2*FLOOR_STEPS+FC_WINDOW; no wrap-around ever.
//  FCn, floor_idx registered from pos: update 1 cycle after pos changes.
//  Windows must not overlap (FLOOR_STEPS > 2*FC_WINDOW); at most one FC high at any time.
//  Motor inputs sampled once per clk; no debounce.
//  Reset mid-move: cabin returns to pos 0 immediately (model, not physics).
// CONFIGURATION
//  PLANT_FAULT_EN defined: ST_FAULT added; entered on code 11, or on a step attempt while at an end stop
//   (pos=0 down, pos=PMAX up). In ST_FAULT: fault=1, moving=0, pos frozen, FCs hold; exit only by reset.
//  PLANT_FAULT_EN undefined: no ST_FAULT; code 11 = stop; end stops saturate silently; fault tied 0.
// STRUCTURE
//  Shared package montacarga_pkg: motor codes MOT_STOP=2'b00, MOT_UP=2'b01, MOT_DN=2'b10, MOT_BAD=2'b11;
//   plant state encoding ST_STOP/ST_UP/ST_DN/ST_FAULT; floor_idx codes FLR_NONE/FLR_1/FLR_2/FLR_3
//   (same 2-bit code as the controller display selector).
//  One sub-module: plant_step_prescaler (clear, enable -> single-cycle step pulse on wrap).
//  Top holds FSM, position counter with saturation, window comparators, FC/floor_idx registers.
// TESTING (PRESCALE=4, FLOOR_STEPS=10, FC_WINDOW=1, PMAX=21)
//  Reset release, S1S0=00 for 20 cycles -> pos=0, FC1=1, FC2=FC3=0, floor_idx=01, moving=0.
//  S0=1 from pos 0 -> pos=1 at 5th cycle; FC1 falls after pos=2; FC2 rises after pos=9; floor_idx=10 at pos 9..11.
//  Up to pos 5, then S1S0=10 -> prescaler cleared, pos=4 four cycles after ST_DN, no step lost/doubled.
//  Hold S0=1 from pos 0 for 200 cycles -> pos stops at 21, FC3=1; with PLANT_FAULT_EN fault=1 after pos 21 tick.
//  S1S0=11 for 10 cycles at pos 10 -> pos stays 10, FC2=1; with PLANT_FAULT_EN fault=1 until reset, S0 then ignored.
//  Assert reset at pos 7 while moving up -> pos=0, FC1=1, moving=0 asynchronously; resume from 0 after release.
//  Closed loop with controller: P3 pulse from floor 1 -> motor 01 until FC3, controller stops at pos 19..21.

Source files
------------

// File: rtl/montacarga_pkg.sv
// Shared codes for the freight elevator: motor drive, plant states, floor selector.
// Used by the controller and by the cabin/shaft plant model.
package montacarga_pkg;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b01;
    localparam logic [1:0] MOT_DN   = 2'b10;
    localparam logic [1:0] MOT_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_UP    = 2'b01,
        ST_DN    = 2'b10,
        ST_FAULT = 2'b11
    } plant_st_e;

    localparam logic [1:0] FLR_NONE = 2'b00;
    localparam logic [1:0] FLR_1    = 2'b01;
    localparam logic [1:0] FLR_2    = 2'b10;
    localparam logic [1:0] FLR_3    = 2'b11;

    // True while p lies within +/-w of centre c (no negative intermediates).
    function automatic logic in_window(input int p, input int c, input int w);
        return ((p + w) >= c) && (p <= (c + w));
    endfunction

endpackage

// File: rtl/montacarga_plant_model_if.sv
// Motor drive / limit-switch bundle between elevator controller and shaft.
// master = controller side, slave = plant side.
interface montacarga_plant_model_if #(
    parameter int POS_W = 9
);
    logic             S0;
    logic             S1;
    logic             FC1;
    logic             FC2;
    logic             FC3;
    logic [POS_W-1:0] pos;
    logic             moving;
    logic [1:0]       floor_idx;
    logic             fault;

    modport master (
        output S0, S1,
        input  FC1, FC2, FC3, pos, moving, floor_idx, fault
    );

    modport slave (
        input  S0, S1,
        output FC1, FC2, FC3, pos, moving, floor_idx, fault
    );
endinterface

// File: rtl/plant_step_prescaler.sv
// Position step timebase: counts 0..PRESCALE-1 while enabled,
// pulses o_step on the terminal count; i_clr discards partial time.
module plant_step_prescaler #(
    parameter int PRESCALE = 4000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_step
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_step = i_en & w_wrap;

    // Cycle counter; clear wins over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/montacarga_plant_model.sv
// Cabin/shaft plant: motor code -> stepped position -> FC1..FC3 limit switches.
// Optional PLANT_FAULT_EN adds a latched fault state (illegal code / end-stop push).
module montacarga_plant_model
    import montacarga_pkg::*;
#(
    parameter int PRESCALE    = 4000,
    parameter int FLOOR_STEPS = 100,
    parameter int FC_WINDOW   = 2,
    parameter int POS_W       = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    montacarga_plant_model_if.slave  bus
);
    localparam logic [POS_W-1:0] PMAX = POS_W'(2 * FLOOR_STEPS + FC_WINDOW);

    plant_st_e        r_state;
    plant_st_e        w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [2:0]       r_fc;
    logic [1:0]       r_flr;
    logic [2:0]       w_fc;
    logic [1:0]       w_flr;
    logic [1:0]       w_code;
    logic             w_moving;
    logic             w_clr;
    logic             w_step;
    logic             w_at_top;
    logic             w_at_bot;

    assign w_code   = {bus.S1, bus.S0};
    assign w_moving = (r_state == ST_UP) || (r_state == ST_DN);
    assign w_clr    = (w_state_nxt != r_state);
    assign w_at_top = (r_pos == PMAX);
    assign w_at_bot = (r_pos == '0);

`ifdef PLANT_FAULT_EN
    logic w_end_hit;
    assign w_end_hit = w_step &&
        (((r_state == ST_UP) && (w_code == MOT_UP) && w_at_top) ||
         ((r_state == ST_DN) && (w_code == MOT_DN) && w_at_bot));
`endif

    plant_step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_moving),
        .o_step (w_step)
    );

    // Motor FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state from the sampled motor code.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP, ST_UP, ST_DN: begin
                unique case (w_code)
                    MOT_STOP: w_state_nxt = ST_STOP;
                    MOT_UP:   w_state_nxt = ST_UP;
                    MOT_DN:   w_state_nxt = ST_DN;
`ifdef PLANT_FAULT_EN
                    MOT_BAD:  w_state_nxt = ST_FAULT;
`else
                    MOT_BAD:  w_state_nxt = ST_STOP;
`endif
                endcase
`ifdef PLANT_FAULT_EN
                if (w_end_hit) begin
                    w_state_nxt = ST_FAULT;
                end
`endif
            end
`ifdef PLANT_FAULT_EN
            default: w_state_nxt = ST_FAULT;
`else
            default: w_state_nxt = ST_STOP;
`endif
        endcase
    end

    // Position counter; steps only while the direction holds, saturating at the end stops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos <= '0;
        end else if (w_step && !w_clr) begin
            unique case (1'b1)
                (r_state == ST_UP) && !w_at_top: r_pos <= r_pos + 1'b1;
                (r_state == ST_DN) && !w_at_bot: r_pos <= r_pos - 1'b1;
                default:                         r_pos <= r_pos;
            endcase
        end
    end

    // Floor window comparators and selector code.
    always_comb begin
        w_fc[0] = in_window(int'(r_pos), 0, FC_WINDOW);
        w_fc[1] = in_window(int'(r_pos), FLOOR_STEPS, FC_WINDOW);
        w_fc[2] = in_window(int'(r_pos), 2 * FLOOR_STEPS, FC_WINDOW);
        w_flr   = FLR_NONE;
        unique case (1'b1)
            w_fc[0]: w_flr = FLR_1;
            w_fc[1]: w_flr = FLR_2;
            w_fc[2]: w_flr = FLR_3;
            default: w_flr = FLR_NONE;
        endcase
    end

    // Registered limit switches and floor index, one cycle behind pos.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fc  <= 3'b001;
            r_flr <= FLR_1;
        end else begin
            r_fc  <= w_fc;
            r_flr <= w_flr;
        end
    end

    assign bus.FC1       = r_fc[0];
    assign bus.FC2       = r_fc[1];
    assign bus.FC3       = r_fc[2];
    assign bus.pos       = r_pos;
    assign bus.moving    = w_moving;
    assign bus.floor_idx = r_flr;
`ifdef PLANT_FAULT_EN
    assign bus.fault     = (r_state == ST_FAULT);
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_montacarga_plant_model.sv
// Directed bench for montacarga_plant_model (PRESCALE=4, FLOOR_STEPS=10, FC_WINDOW=1).
// Works with and without PLANT_FAULT_EN.
module tb_montacarga_plant_model;
    localparam int PS = 4;
    localparam int FS = 10;
    localparam int FW = 1;
    localparam int PW = 9;
`ifdef PLANT_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    montacarga_plant_model_if #(.POS_W(PW)) bus ();

    montacarga_plant_model #(
        .PRESCALE    (PS),
        .FLOOR_STEPS (FS),
        .FC_WINDOW   (FW),
        .POS_W       (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] code;
        int         n;
        int         pos;
        logic [2:0] fc;
        logic [1:0] flr;
        logic       mov;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int pos, input logic [2:0] fc,
                         input logic [1:0] flr, input logic mov, input logic flt);
        logic [15:0] act;
        logic [15:0] exp;
        act = {bus.pos, bus.FC3, bus.FC2, bus.FC1, bus.floor_idx, bus.moving, bus.fault};
        exp = {pos[8:0], fc, flr, mov, flt};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pos=%0d fc=%b flr=%b mov=%b flt=%b, want pos=%0d fc=%b flr=%b mov=%b flt=%b",
                     nm, act[15:7], act[6:4], act[3:2], act[1], act[0],
                     exp[15:7], exp[6:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic [1:0] code, input int n);
        {bus.S1, bus.S0} = code;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b0;
        {bus.S1, bus.S0} = 2'b00;
        #1;
        check(nm, 0, 3'b001, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{"idle",      2'b00, 20, 0,  3'b001, 2'b01, 1'b0};
        vecs[1]  = '{"up_wait",   2'b01, 4,  0,  3'b001, 2'b01, 1'b1};
        vecs[2]  = '{"up_first",  2'b01, 1,  1,  3'b001, 2'b01, 1'b1};
        vecs[3]  = '{"up_p2",     2'b01, 4,  2,  3'b001, 2'b01, 1'b1};
        vecs[4]  = '{"fc1_off",   2'b01, 1,  2,  3'b000, 2'b00, 1'b1};
        vecs[5]  = '{"up_p9",     2'b01, 27, 9,  3'b000, 2'b00, 1'b1};
        vecs[6]  = '{"fc2_on",    2'b01, 1,  9,  3'b010, 2'b10, 1'b1};
        vecs[7]  = '{"up_p10",    2'b01, 3,  10, 3'b010, 2'b10, 1'b1};
        vecs[8]  = '{"up_p11",    2'b01, 4,  11, 3'b010, 2'b10, 1'b1};
        vecs[9]  = '{"up_p12",    2'b01, 4,  12, 3'b010, 2'b10, 1'b1};
        vecs[10] = '{"fc2_off",   2'b01, 1,  12, 3'b000, 2'b00, 1'b1};
        vecs[11] = '{"rev",       2'b10, 1,  12, 3'b000, 2'b00, 1'b1};
        vecs[12] = '{"rev_wait",  2'b10, 3,  12, 3'b000, 2'b00, 1'b1};
        vecs[13] = '{"rev_step",  2'b10, 1,  11, 3'b000, 2'b00, 1'b1};
        vecs[14] = '{"rev_fc",    2'b10, 1,  11, 3'b010, 2'b10, 1'b1};
        vecs[15] = '{"stop",      2'b00, 1,  11, 3'b010, 2'b10, 1'b0};
        vecs[16] = '{"stop_hold", 2'b00, 10, 11, 3'b010, 2'b10, 1'b0};

        {bus.S1, bus.S0} = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 0, 3'b001, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].code, vecs[i].n);
            check(vecs[i].name, vecs[i].pos, vecs[i].fc, vecs[i].flr, vecs[i].mov, 1'b0);
        end

        drive(2'b11, 10);
        check("bad_hold", 11, 3'b010, 2'b10, 1'b0, FE);
        drive(2'b01, 20);
        check("bad_after", FE ? 11 : 15, FE ? 3'b010 : 3'b000,
              FE ? 2'b10 : 2'b00, !FE, FE);

        do_reset("rst_a");
        drive(2'b10, 20);
        check("bot_stop", 0, 3'b001, 2'b01, !FE, FE);

        do_reset("rst_b");
        drive(2'b01, 200);
        check("top_stop", 21, 3'b100, 2'b11, !FE, FE);
        drive(2'b00, 5);
        check("top_hold", 21, 3'b100, 2'b11, 1'b0, FE);

        do_reset("rst_c");
        drive(2'b01, 30);
        check("mid_p7", 7, 3'b000, 2'b00, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst", 0, 3'b001, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b01, 5);
        check("resume", 1, 3'b001, 2'b01, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
